seg_scan_driver: RTL

Drives the 8-digit seven-segment tube from the 32-bit word the CPU writes to IO address 0xFFFF0014 (the `seg` register in the IO decoder).
- Time-multiplexes 8 hex digits, one nibble per digit, with a programmable refresh prescaler.
- Samples the input word only at frame start, so a digit never shows a value from a different write than its neighbours.
- Sits between the IO decoder's `seg` output and the board tube pins.

---
 rtl/seg_pkg.sv | 19 +
 rtl/seg_scan_driver_if.sv | 18 +
 rtl/seg_hex_decode.sv | 13 +
 rtl/seg_scan_driver.sv | 78 +++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and types for the seven-segment scan driver.
//   NUM_DIGITS  - digits on the tube (fixed at 8)
//   SEG_BLANK   - active-low "all segments off" / "all anodes off" pattern
//   HEX_CODES   - active-low {dp,g,f,e,d,c,b,a} codes for nibbles 0..F (dp off)
//   digit_idx_t - index of the digit currently being scanned
package seg_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [7:0] HEX_CODES [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    typedef logic [2:0] digit_idx_t;

endpackage

// File: rtl/seg_scan_driver_if.sv
// seg_scan_driver_if: bundles the display word and the tube pins.
//   seg_in  [31:0] - display word, nibble i -> digit i (digit 0 rightmost)
//   an      [7:0]  - digit enables, active-low
//   seg_out [7:0]  - segments {dp,g,f,e,d,c,b,a}, active-low
// Signalling: no valid/ready handshake. seg_in is a level held by the IO
// register and is only sampled at frame start; an/seg_out are registered
// levels that are always valid outside reset.
// Modports: master = IO decoder / bench side, slave = scan driver side.
interface seg_scan_driver_if;

    logic [31:0] seg_in;
    logic [7:0]  an;
    logic [7:0]  seg_out;

    modport master (output seg_in, input an, input seg_out);
    modport slave  (input seg_in, output an, output seg_out);

endinterface

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational nibble -> active-low seven-segment code.
//   nibble [3:0] - hex value to display
//   code   [7:0] - {dp,g,f,e,d,c,b,a}, active-low, dp always off
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] code
);

    assign code = HEX_CODES[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexes an 8-digit seven-segment tube from the
// 32-bit word written by the CPU. Each digit is lit for DIV_CYCLES clocks; the
// word is copied into a shadow register at frame start so every digit of a
// frame comes from the same write.
//   clk  - system clock
//   rst  - asynchronous, active-high reset (blanks the tube immediately)
//   bus  - seg_scan_driver_if.slave: seg_in in, an/seg_out out
// Optional build macro SEG_LEADING_ZERO_BLANK_EN: blank leading-zero digits
// (digit 0 is always shown; scan timing is unchanged).
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIV_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    seg_scan_driver_if.slave bus
);

    localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    digit_idx_t    idx_q, idx_d;
    logic [31:0]   shadow_q, shadow_d;
    logic [7:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;

    logic          tick;
    logic          blank;
    logic [3:0]    nibble;
    logic [7:0]    hex_code;

    seg_hex_decode u_hex_decode (
        .nibble (nibble),
        .code   (hex_code)
    );

    always_comb begin
        tick     = (cnt_q == CNT_MAX);
        cnt_d    = tick ? '0 : cnt_q + 1'b1;
        idx_d    = tick ? idx_q + 3'd1 : idx_q;
        // Frame start is the first cycle of digit 0; that is the only point
        // where the display word is taken.
        shadow_d = (cnt_q == '0 && idx_q == 3'd0) ? bus.seg_in : shadow_q;

        nibble   = shadow_q[{idx_q, 2'b00} +: 4];

        blank    = 1'b0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        // A digit is a leading zero when it and every digit above it are zero.
        blank    = (idx_q != 3'd0) && ((shadow_q >> {idx_q, 2'b00}) == 32'd0);
`endif

        an_d     = blank ? SEG_BLANK : ~(8'b1 << idx_q);
        seg_d    = blank ? SEG_BLANK : hex_code;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            idx_q    <= 3'd0;
            shadow_q <= 32'd0;
            an_q     <= SEG_BLANK;
            seg_q    <= SEG_BLANK;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
        end
    end

    assign bus.an      = an_q;
    assign bus.seg_out = seg_q;

endmodule
